ntt_coef_packer: RTL and testbench

NTT_COEF_PACKER -- requirements
Module: ntt_coef_packer

---
 rtl/ntt_pkg.sv | 11 +
 rtl/ntt_coef_packer.sv | 126 ++++++++++++
 tb/tb_ntt_coef_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants: modulus and delay-line word geometry.
// Latency: none (constants only).
// Backpressure: not applicable.
package ntt_pkg;

    localparam int unsigned Q      = 32'd8380417;
    localparam int          COEF_W = 24;
    localparam int          LANES  = 4;
    localparam int          WORD_W = LANES * COEF_W;

endpackage

// File: rtl/ntt_coef_packer.sv
// Packs four coefficient lanes (lane 0 in the LSBs) into one word for the delay line.
// Latency: word_valid_o rises 1 cycle after the accept that closes a word.
// Backpressure: coef_ready_o = !word_valid_o | word_ready_i; a held word stalls input.
// Optional range check: define NTT_PACK_RANGECHK_EN for a sticky err_o on coef_i >= Q.
module ntt_coef_packer #(
    parameter int N_COEF = 256,
    parameter int COEF_W = ntt_pkg::COEF_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [COEF_W-1:0]                  coef_i,
    input  logic                               coef_valid_i,
    input  logic                               coef_last_i,
    output logic                               coef_ready_o,
    output logic [ntt_pkg::LANES*COEF_W-1:0]   word_o,
    output logic                               word_valid_o,
    input  logic                               word_ready_i,
    output logic                               word_last_o,
    output logic                               err_o
);

    localparam int WORD_W = ntt_pkg::LANES * COEF_W;
    localparam int CNT_W  = $clog2(N_COEF);

    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_vld_q, word_vld_d;
    logic              word_last_q, word_last_d;

    logic              accept;
    logic              close_poly;
    logic              close_word;
    logic [WORD_W-1:0] assembled;

    assign coef_ready_o = !word_vld_q | word_ready_i;
    assign accept       = coef_valid_i & coef_ready_o;
    assign word_o       = word_q;
    assign word_valid_o = word_vld_q;
    assign word_last_o  = word_last_q;

    // Lane insertion, word closing and output-register next state.
    always_comb begin
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        word_d      = word_q;
        word_vld_d  = word_vld_q;
        word_last_d = word_last_q;

        close_poly = coef_last_i | (cnt_q == CNT_W'(N_COEF - 1));
        close_word = (lane_q == 2'd3) | close_poly;

        // Buffer is cleared on every close, so lanes above the current one
        // are already zero when a polynomial ends early.
        assembled = buf_q;
        assembled[lane_q*COEF_W +: COEF_W] = coef_i;

        if (word_vld_q && word_ready_i) begin
            word_vld_d  = 1'b0;
            word_last_d = 1'b0;
        end

        if (accept) begin
            if (close_word) begin
                buf_d       = '0;
                word_d      = assembled;
                word_vld_d  = 1'b1;
                word_last_d = close_poly;
            end else begin
                buf_d = assembled;
            end

            if (close_poly) begin
                lane_d = 2'd0;
                cnt_d  = '0;
            end else begin
                lane_d = lane_q + 2'd1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    // Assembly state and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q      <= 2'd0;
            cnt_q       <= '0;
            buf_q       <= '0;
            word_q      <= '0;
            word_vld_q  <= 1'b0;
            word_last_q <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            word_q      <= word_d;
            word_vld_q  <= word_vld_d;
            word_last_q <= word_last_d;
        end
    end

`ifdef NTT_PACK_RANGECHK_EN
    logic err_q, err_d;

    // Sticky flag: any accepted coefficient outside [0, Q) sets it until reset.
    always_comb begin
        err_d = err_q | (accept & (coef_i >= COEF_W'(ntt_pkg::Q)));
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_coef_packer.sv
// Scoreboard bench for ntt_coef_packer with a queue-based packing model.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Downstream ready is either held high, randomized, or held low.
module tb_ntt_coef_packer;

    localparam int          W = 24;
    localparam int          N = 256;
    localparam int unsigned Q = 32'd8380417;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  coef_i;
    logic          coef_valid_i;
    logic          coef_last_i;
    logic          coef_ready_o;
    logic [4*W-1:0] word_o;
    logic          word_valid_o;
    logic          word_ready_i;
    logic          word_last_o;
    logic          err_o;

    ntt_coef_packer #(.N_COEF(N), .COEF_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .coef_i       (coef_i),
        .coef_valid_i (coef_valid_i),
        .coef_last_i  (coef_last_i),
        .coef_ready_o (coef_ready_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_last_o  (word_last_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*W-1:0] word;
        logic           last;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] part_q[$];
    int           idx;
    logic         exp_err;
    int           total = 0;
    int           bad = 0;
    int           rdy_mode = 0;

    task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: collect coefficients, emit a word when 4 are held,
    // when the polynomial is flagged last, or when N coefficients have arrived.
    function automatic bit model_accept(input logic [W-1:0] c, input logic l);
        logic [4*W-1:0] w;
        bit             ends;
        exp_t           e;
        part_q.push_back(c);
        idx++;
`ifdef NTT_PACK_RANGECHK_EN
        if (32'(c) >= Q) exp_err = 1'b1;
`endif
        ends = l || (idx == N);
        if (part_q.size() == 4 || ends) begin
            w = '0;
            for (int i = 0; i < part_q.size(); i++) w[i*W +: W] = part_q[i];
            e.word = w;
            e.last = ends;
            sb_q.push_back(e);
            part_q.delete();
            if (ends) idx = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        part_q.delete();
        idx     = 0;
        exp_err = 1'b0;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] c, input logic l);
        bit done = 0;
        bit rdy;
        coef_i       = c;
        coef_last_i  = l;
        coef_valid_i = 1'b1;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            rdy = coef_ready_o;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
                if (model_accept(c, l)) chk("close_latency_vld", {95'd0, word_valid_o}, 96'd1);
                chk("err_after_accept", {95'd0, err_o}, {95'd0, exp_err});
            end
        end
        coef_valid_i = 1'b0;
        coef_last_i  = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: coef %h never accepted", c);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        rdy_mode = 0;
        while (sb_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", sb_q.size());
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    // Downstream ready generator.
    initial begin
        word_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       word_ready_i = 1'b1;
                1:       word_ready_i = 1'($urandom_range(0, 1));
                default: word_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: every output handshake pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && word_valid_o && word_ready_i) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h expected none", word_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("word", word_o, e.word);
                    chk("word_last", {95'd0, word_last_o}, {95'd0, e.last});
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        coef_i       = '0;
        coef_valid_i = 1'b0;
        coef_last_i  = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_word_vld", {95'd0, word_valid_o}, 96'd0);
        chk("rst_word", word_o, 96'd0);
        chk("rst_word_last", {95'd0, word_last_o}, 96'd0);
        chk("rst_err", {95'd0, err_o}, 96'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_coef_rdy", {95'd0, coef_ready_o}, 96'd1);

        // Basic four-lane word.
        for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
        chk("basic_word", word_o, {24'd4, 24'd3, 24'd2, 24'd1});
        chk("basic_last", {95'd0, word_last_o}, 96'd0);
        wait_drain();

        // Early close by last, upper lanes zero.
        send(24'd5, 1'b0);
        send(24'd6, 1'b1);
        chk("short_word", word_o, {48'd0, 24'd6, 24'd5});
        chk("short_last", {95'd0, word_last_o}, 96'd1);
        wait_drain();

        // Full polynomial without last, random downstream stalls.
        rdy_mode = 1;
        for (int i = 0; i < N; i++) send(W'(i), 1'b0);
        wait_drain();

        // Downstream stalled with a word pending.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 11; i <= 14; i++) send(W'(i), 1'b0);
        fork
            send(24'd15, 1'b0);
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("hold_coef_rdy", {95'd0, coef_ready_o}, 96'd0);
                    chk("hold_vld", {95'd0, word_valid_o}, 96'd1);
                    chk("hold_word", word_o, {24'd14, 24'd13, 24'd12, 24'd11});
                end
                rdy_mode = 0;
            end
        join
        for (int i = 16; i <= 18; i++) send(W'(i), 1'b0);
        wait_drain();

        // Randomized coefficients and polynomial ends.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++)
            send(W'($urandom_range(0, Q - 1)), ($urandom_range(0, 19) == 0));
        wait_drain();

        // Reset mid-word discards the partial word.
        send(24'd100, 1'b0);
        send(24'd101, 1'b0);
        wait_drain();
        pulse_rst();
        for (int i = 7; i <= 10; i++) send(W'(i), 1'b0);
        chk("post_rst_word", word_o, {24'd10, 24'd9, 24'd8, 24'd7});
        wait_drain();

        // Range check boundary.
        send(W'(Q - 1), 1'b0);
        send(W'(Q), 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("err_sticky", {95'd0, err_o}, {95'd0, exp_err});
        end
        send(24'd1, 1'b0);
        send(24'd2, 1'b0);
        wait_drain();
        pulse_rst();
        chk("err_cleared", {95'd0, err_o}, 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
